mips_alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the MIPS datapath; successor to the single-cycle 32-bit ALU.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/mips_alu_mc.sv | 178 +++++++++++++++++
 tb/tb_mips_alu_mc.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle MIPS ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_OR   = 4'h0,
        OP_AND  = 4'h1,
        OP_XOR  = 4'h2,
        OP_SLL  = 4'h3,
        OP_SRL  = 4'h4,
        OP_SUB  = 4'h5,
        OP_ADD  = 4'h6,
        OP_NOR  = 4'h7,
        OP_NAND = 4'h8,
        OP_SLT  = 4'h9,
        OP_MUL  = 4'hA,
        OP_CLR  = 4'hB,
        OP_SET  = 4'hC,
        OP_ADDR = 4'hD,
        OP_ANDN = 4'hE,
        OP_XNOR = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of a*b.
// done is asserted combinationally during the final iteration and product then carries
// the completed sum, so the caller can register it on that same edge.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;

    // Partial-product accumulation for the current multiplier bit.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    assign done    = busy && (count == CNT_W'(1));
    assign product = acc_next;

    // Control: iteration counter and busy flag, cleared by reset (aborts an in-flight multiply).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CNT_W'(WIDTH);
        end else if (busy) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Datapath: operands latched at start, then shifted one bit per iteration.
    always_ff @(posedge clk) begin
        if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS ALU with valid/ready handshakes on both sides and registered N/Z/C/V flags.
// Non-MUL ops finish on the accept edge; MUL optionally runs through the iterative unit.
module mips_alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int SHAMT_W = $clog2(WIDTH);

    alu_state_e state;
    alu_state_e state_next;
    alu_op_e    op_e;

    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic             load;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] res_d;
    alu_flags_t       alu_flg;
    alu_flags_t       flg_d;
    alu_flags_t       flags_q;

    logic [WIDTH:0]          sum_add;
    logic [WIDTH:0]          sum_sub;
    logic [WIDTH:0]          sum_addr;
    logic [WIDTH-1:0]        b_sh2;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    c_bit;
    logic                    v_bit;

    assign op_e      = alu_op_e'(op);
    assign a_s       = a;
    assign b_s       = b;
    assign in_ready  = ((state == IDLE) || ((state == DONE) && out_ready)) && !mul_busy;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    generate
        if (MUL_ITER != 0) begin : g_mul_iter
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_mul_none
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // Single-cycle op unit; arithmetic is carried one bit wider to expose the carry.
    always_comb begin
        b_sh2    = b << 2;
        sum_add  = {1'b0, a} + {1'b0, b};
        sum_sub  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        sum_addr = {1'b0, a} + {1'b0, b_sh2};
        alu_res  = '0;
        c_bit    = 1'b0;
        v_bit    = 1'b0;
        case (op_e)
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << b[SHAMT_W-1:0];
            OP_SRL:  alu_res = a >> b[SHAMT_W-1:0];
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                c_bit   = sum_sub[WIDTH];
                v_bit   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                c_bit   = sum_add[WIDTH];
                v_bit   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOR:  alu_res = ~(a | b);
            OP_NAND: alu_res = ~(a & b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_MUL:  alu_res = (MUL_ITER != 0) ? '0 : a * b;
            OP_CLR:  alu_res = '0;
            OP_SET:  alu_res = '1;
            OP_ADDR: begin
                alu_res = sum_addr[WIDTH-1:0];
                c_bit   = sum_addr[WIDTH];
                v_bit   = (a[WIDTH-1] == b_sh2[WIDTH-1]) && (sum_addr[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ANDN: alu_res = a & ~b;
            OP_XNOR: alu_res = ~(a ^ b);
            default: alu_res = '0;
        endcase
        alu_flg = '{n: alu_res[WIDTH-1], z: (alu_res == '0), c: c_bit, v: v_bit};
    end

    // Next-state logic: accept from IDLE or a draining DONE, hold DONE while stalled.
    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        load       = 1'b0;
        res_d      = alu_res;
        flg_d      = alu_flg;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if ((op_e == OP_MUL) && (MUL_ITER != 0)) begin
                        mul_start  = 1'b1;
                        state_next = MUL;
                    end else begin
                        load       = 1'b1;
                        state_next = DONE;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    load       = 1'b1;
                    res_d      = mul_product;
                    flg_d      = '{n: mul_product[WIDTH-1], z: (mul_product == '0), c: 1'b0, v: 1'b0};
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result and flag registers, loaded when an operation completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            flags_q <= '0;
        end else if (load) begin
            result  <= res_d;
            flags_q <= flg_d;
        end
    end

    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_mips_alu_mc.sv
// Bench for mips_alu_mc: a 32-bit and a 16-bit instance share the input side; sel16 picks
// which instance's outputs are observed.
module tb_mips_alu_mc;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sel16;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_ready32, out_valid32, n32, z32, c32, v32;
    logic [31:0] result32;
    logic        in_ready16, out_valid16, n16, z16, c16, v16;
    logic [15:0] result16;

    logic        cur_ready;
    logic        cur_valid;
    logic [31:0] cur_result;
    logic [3:0]  cur_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_alu_mc #(.WIDTH(32), .MUL_ITER(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32), .op(op),
        .a(a), .b(b), .out_valid(out_valid32), .out_ready(out_ready), .result(result32),
        .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
    );

    mips_alu_mc #(.WIDTH(16), .MUL_ITER(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .op(op),
        .a(a[15:0]), .b(b[15:0]), .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
        .flag_n(n16), .flag_z(z16), .flag_c(c16), .flag_v(v16)
    );

    always_comb begin
        if (sel16) begin
            cur_ready  = in_ready16;
            cur_valid  = out_valid16;
            cur_result = {16'h0, result16};
            cur_flags  = {n16, z16, c16, v16};
        end else begin
            cur_ready  = in_ready32;
            cur_valid  = out_valid32;
            cur_result = result32;
            cur_flags  = {n32, z32, c32, v32};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model from the opcode definitions, using wide integer arithmetic.
    function automatic void model(input int w, input logic [3:0] o, input logic [31:0] ai,
                                  input logic [31:0] bi, output logic [31:0] r, output logic [3:0] f);
        logic [63:0] mask, x, y, y4, full;
        longint      sx, sy, sy4, s, smax, smin;
        logic        c, v;
        int          sh;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, ai} & mask;
        y    = {32'd0, bi} & mask;
        y4   = (y * 64'd4) & mask;
        sx   = x[w-1]  ? longint'(x)  - longint'(mask) - 1 : longint'(x);
        sy   = y[w-1]  ? longint'(y)  - longint'(mask) - 1 : longint'(y);
        sy4  = y4[w-1] ? longint'(y4) - longint'(mask) - 1 : longint'(y4);
        smax = longint'(mask >> 1);
        smin = -smax - 1;
        sh   = int'(y % 64'(w));
        c    = 1'b0;
        v    = 1'b0;
        s    = 0;
        case (o)
            4'h0: full = x | y;
            4'h1: full = x & y;
            4'h2: full = x ^ y;
            4'h3: full = x << sh;
            4'h4: full = x >> sh;
            4'h5: begin full = x - y; c = (x >= y); s = sx - sy; v = (s > smax) || (s < smin); end
            4'h6: begin full = x + y; c = (full > mask); s = sx + sy; v = (s > smax) || (s < smin); end
            4'h7: full = ~(x | y);
            4'h8: full = ~(x & y);
            4'h9: full = (sx < sy) ? 64'd1 : 64'd0;
            4'hA: full = x * y;
            4'hB: full = 64'd0;
            4'hC: full = mask;
            4'hD: begin full = x + y4; c = (full > mask); s = sx + sy4; v = (s > smax) || (s < smin); end
            4'hE: full = x & ~y;
            default: full = ~(x ^ y);
        endcase
        full = full & mask;
        r    = full[31:0];
        f    = {full[w-1], (full == 64'd0), c, v};
    endfunction

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] r, input logic [3:0] f, input int lat);
        vec_t t;
        t.op = o; t.a = x; t.b = y; t.r = r; t.f = f; t.lat = lat;
        return t;
    endfunction

    function automatic logic [31:0] rnd_val(input int w);
        logic [31:0] one;
        one = 32'd1;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return one << (w - 1);
            3: return (one << (w - 1)) - 32'd1;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with out_ready=1 and wait (bounded) for its result.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int g;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        g = 0;
        while (!cur_ready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) check("accept_timeout", 64'(cur_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!cur_valid && lat < 200) begin @(negedge clk); lat++; end
        r = cur_result;
        f = cur_flags;
    endtask

    task automatic run_chk(input string name, input int w, input logic [3:0] o,
                           input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        int          lat;
        model(w, o, x, y, er, ef);
        run_op(o, x, y, r, f, lat);
        check({name, "_res"}, 64'(r), 64'(er));
        check({name, "_flg"}, 64'(f), 64'(ef));
        check({name, "_lat"}, 64'(lat), (o == 4'hA) ? 64'(w + 1) : 64'd1);
    endtask

    // MUL with in_valid pulses and operand changes while it runs.
    task automatic mul_pulse(input string name, input int w, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] er);
        int g, lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; op = 4'hA; a = x; b = y;
        g = 0;
        while (!cur_ready && g < 100) begin @(negedge clk); g++; end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!cur_valid) begin
                check({name, "_busy_ready"}, 64'(cur_ready), 64'd0);
                if (lat < 10) begin
                    in_valid = lat[0]; op = 4'h6; a = $urandom; b = $urandom;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end while (!cur_valid && lat < 200);
        check({name, "_lat"}, 64'(lat), 64'(w + 1));
        check({name, "_res"}, 64'(cur_result), 64'(er));
        check({name, "_nz"}, 64'(cur_flags), {60'd0, er[w-1], (er == 32'd0), 2'b00});
    endtask

    initial begin
        vec_t        vt[$];
        vec_t        v16t[$];
        logic [31:0] r, r0, er;
        logic [3:0]  f, f0, ef;
        int          lat;
        logic [31:0] b2b_a[3], b2b_b[3], b2b_r[3];
        logic [3:0]  b2b_op[3];

        vt.push_back(mk(4'h6, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001, 1));
        vt.push_back(mk(4'h5, 32'h5,         32'h5,         32'h0,         4'b0110, 1));
        vt.push_back(mk(4'h5, 32'h0,         32'h1,         32'hFFFF_FFFF, 4'b1000, 1));
        vt.push_back(mk(4'hA, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 4'b1000, 33));
        vt.push_back(mk(4'h0, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 4'b0000, 1));
        vt.push_back(mk(4'h3, 32'h1,         32'd35,        32'h8,         4'b0000, 1));
        vt.push_back(mk(4'h9, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1));
        vt.push_back(mk(4'h9, 32'h1,         32'hFFFF_FFFF, 32'h0,         4'b0100, 1));
        vt.push_back(mk(4'hB, 32'h1234_5678, 32'h9,         32'h0,         4'b0100, 1));
        vt.push_back(mk(4'hC, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1000, 1));
        vt.push_back(mk(4'hD, 32'h1,         32'h4000_0000, 32'h1,         4'b0000, 1));
        vt.push_back(mk(4'hD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0003, 4'b1001, 1));
        vt.push_back(mk(4'h6, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b0110, 1));
        vt.push_back(mk(4'h5, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0011, 1));
        vt.push_back(mk(4'hE, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_00F0, 4'b0000, 1));
        vt.push_back(mk(4'hF, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1000, 1));
        vt.push_back(mk(4'h4, 32'h8000_0000, 32'h3F,        32'h1,         4'b0000, 1));
        vt.push_back(mk(4'h7, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1000, 1));
        vt.push_back(mk(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         4'b0100, 1));
        vt.push_back(mk(4'h2, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 4'b0000, 1));
        vt.push_back(mk(4'h1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1));

        v16t.push_back(mk(4'h6, 32'h7FFF, 32'h1,    32'h8000, 4'b1001, 1));
        v16t.push_back(mk(4'h5, 32'h5,    32'h5,    32'h0,    4'b0110, 1));
        v16t.push_back(mk(4'h5, 32'h0,    32'h1,    32'hFFFF, 4'b1000, 1));
        v16t.push_back(mk(4'hA, 32'h00FF, 32'h0101, 32'hFFFF, 4'b1000, 17));
        v16t.push_back(mk(4'hD, 32'h7FFF, 32'h1,    32'h8003, 4'b1001, 1));

        // Reset state of both instances.
        sel16 = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'h0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel16 = s[0];
            #1;
            check($sformatf("rst%0d_out_valid", s), 64'(cur_valid), 64'd0);
            check($sformatf("rst%0d_in_ready", s), 64'(cur_ready), 64'd1);
            check($sformatf("rst%0d_result", s), 64'(cur_result), 64'd0);
            check($sformatf("rst%0d_flags", s), 64'(cur_flags), 64'd0);
        end
        sel16 = 1'b0;
        rst_n = 1'b1;

        // Directed vector table, 32-bit.
        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, r, f, lat);
            check($sformatf("vec%0d_res", i), 64'(r), 64'(vt[i].r));
            check($sformatf("vec%0d_flg", i), 64'(f), 64'(vt[i].f));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
        end

        // Back-to-back OR, SLL, SLT: one result per cycle, in order.
        b2b_op = '{4'h0, 4'h3, 4'h9};
        b2b_a  = '{32'h1200_0034, 32'h1, 32'hFFFF_FFFF};
        b2b_b  = '{32'h0000_5600, 32'd35, 32'h1};
        b2b_r  = '{32'h1200_5634, 32'h8, 32'h1};
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; op = b2b_op[0]; a = b2b_a[0]; b = b2b_b[0];
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b%0d_in_ready", i), 64'(cur_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b%0d_valid", i), 64'(cur_valid), 64'd1);
            check($sformatf("b2b%0d_res", i), 64'(cur_result), 64'(b2b_r[i]));
            if (i < 2) begin
                op = b2b_op[i+1]; a = b2b_a[i+1]; b = b2b_b[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);

        // Stall in DONE for 5 cycles, then release with the next op accepted on that edge.
        model(32, 4'h2, 32'h1234_5678, 32'h0F0F_0F0F, er, ef);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 4'h2; a = 32'h1234_5678; b = 32'h0F0F_0F0F;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        r0 = cur_result; f0 = cur_flags;
        check("stall_res", 64'(r0), 64'(er));
        check("stall_flg", 64'(f0), 64'(ef));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_valid", k), 64'(cur_valid), 64'd1);
            check($sformatf("stall%0d_in_ready", k), 64'(cur_ready), 64'd0);
            check($sformatf("stall%0d_hold", k), 64'({cur_result, cur_flags}), 64'({r0, f0}));
            @(negedge clk);
            if (k < 4) begin
                in_valid = 1'b1; op = 4'h6; a = $urandom; b = $urandom;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b1; op = 4'h6; a = 32'h100; b = 32'h23; out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(cur_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("release_valid", 64'(cur_valid), 64'd1);
        check("release_res", 64'(cur_result), 64'h123);
        @(negedge clk);

        // Iterative MUL with ignored in_valid pulses, 32-bit.
        mul_pulse("mul32", 32, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
        @(negedge clk);

        // Reset applied mid-MUL (count=10) aborts it.
        @(negedge clk);
        in_valid = 1'b1; op = 4'hA; a = 32'h1357_9BDF; b = 32'h2468_ACE1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (22) @(negedge clk);
        check("premid_busy", 64'(cur_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 64'(cur_valid), 64'd0);
        check("midrst_result", 64'(cur_result), 64'd0);
        check("midrst_in_ready", 64'(cur_ready), 64'd1);
        check("midrst_flags", 64'(cur_flags), 64'd0);
        rst_n = 1'b1;
        run_chk("post_rst_add", 32, 4'h6, 32'h0000_1111, 32'h0000_2222);

        // Randomized ops against the reference model, 32-bit.
        for (int i = 0; i < 120; i++) begin
            run_chk($sformatf("rnd32_%0d", i), 32, 4'($urandom_range(0, 15)), rnd_val(32), rnd_val(32));
        end

        // 16-bit instance: directed vectors, MUL with pulses, random.
        @(negedge clk);
        @(negedge clk);
        sel16 = 1'b1;
        foreach (v16t[i]) begin
            run_op(v16t[i].op, v16t[i].a, v16t[i].b, r, f, lat);
            check($sformatf("v16_%0d_res", i), 64'(r), 64'(v16t[i].r));
            check($sformatf("v16_%0d_flg", i), 64'(f), 64'(v16t[i].f));
            check($sformatf("v16_%0d_lat", i), 64'(lat), 64'(v16t[i].lat));
        end
        mul_pulse("mul16", 16, 32'h00FF, 32'h0101, 32'hFFFF);
        for (int i = 0; i < 60; i++) begin
            run_chk($sformatf("rnd16_%0d", i), 16, 4'($urandom_range(0, 15)), rnd_val(16), rnd_val(16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
